multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore-FSM control unit for the multicycle MIPS datapath; successor to the single-cycle opcode/ALU decoder.
- Sequences each instruction over 3–5 states through one shared memory and one ALU.
- Adds ADDI, a memory-ready wait handshake, illegal-instruction flagging and a state debug port.
- Sits between the instruction register (opcode/funct) and the datapath muxes, enables and memory.

Parameters:
- ALU_CNTRL_WIDTH_P, 3, ALU control word width.
- FUNCT_WIDTH_P, 6, R-type funct field width.
- OP_WIDTH_P, 6, opcode field width.
- STATE_WIDTH_P, 4, state register width; must be >= 4.

Ports:
- i_clk  input  1  sole clock; all state updates on its rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_opcode  input  OP_WIDTH_P  opcode from instruction register.
- i_function  input  FUNCT_WIDTH_P  funct field from instruction register.
- i_zero  input  1  ALU zero flag.
- i_mem_ready  input  1  memory has completed the current access this cycle.
- o_iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- o_mem_wr_en  output  1  memory write enable.
- o_ir_wr_en  output  1  instruction register load.
- o_pc_en  output  1  PC load: pc_write OR (branch AND i_zero).
- o_pc_src_sel  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- o_alu_src_a_sel  output  1  0 = PC, 1 = register A.
- o_alu_src_b_sel  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- o_alu_cntrl  output  ALU_CNTRL_WIDTH_P  ALU operation.
- o_reg_wr_addr_sel  output  1  0 = rt, 1 = rd.
- o_reg_wr_data_sel  output  1  0 = ALUOut, 1 = memory data.
- o_reg_wr_en  output  1  register file write enable.
- o_illegal  output  1  unsupported opcode or funct detected.
- o_state  output  STATE_WIDTH_P  current state, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12–15 are unused.
- Opcodes: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- Reset:
  - A rising edge with i_rst=1 loads FETCH.
  - While i_rst=1, every output except o_state is forced to 0.
  - Reset mid-instruction abandons that instruction. No write enable asserts in the cycle that reset is sampled.
- Transitions:
  - FETCH → DECODE when i_mem_ready=1; otherwise stay in FETCH.
  - DECODE → MEMADR (LW, SW), EXECUTE (RTYPE), BRANCH (BEQ), ADDIEXEC (ADDI), JUMP (J). Any other opcode → FETCH.
  - MEMADR → MEMRD (LW) or MEMWR (SW).
  - MEMRD → MEMWB when i_mem_ready=1; else stay.
  - MEMWR → FETCH when i_mem_ready=1; else stay.
  - EXECUTE → ALUWB; ADDIEXEC → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP each → FETCH.
  - Unused codes → FETCH.
- Any output not listed for a state is 0. Outputs by state:
  - FETCH: src_a 0, src_b 01, ALU add; o_ir_wr_en and pc_write = i_mem_ready. The PC never increments on a stalled fetch.
  - DECODE: src_a 0, src_b 11, ALU add.
  - MEMADR and ADDIEXEC: src_a 1, src_b 10, ALU add.
  - MEMRD: o_iord 1.
  - MEMWR: o_iord 1, o_mem_wr_en 1, held for every wait cycle.
  - MEMWB: reg_wr_en 1, reg_wr_data_sel 1, reg_wr_addr_sel 0.
  - EXECUTE: src_a 1, src_b 00, ALU from funct.
  - ALUWB: reg_wr_en 1, reg_wr_addr_sel 1.
  - ADDIWB: reg_wr_en 1, reg_wr_addr_sel 0.
  - BRANCH: src_a 1, src_b 00, ALU sub, pc_src 01, branch 1.
  - JUMP: pc_src 10, pc_write 1.
  - Unused codes: all outputs 0.
- ALU control:
  - Encodings: add = 010, sub = 110.
  - Funct decode (EXECUTE only): 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Other funct → 010, with o_illegal=1 during EXECUTE. ALUWB still writes the result.
  - For ALU_CNTRL_WIDTH_P > 3, codes are zero-extended.
- o_illegal is combinational. It is high for exactly one cycle: DECODE with an unsupported opcode, or EXECUTE with an unsupported funct.
- Cycle counts with i_mem_ready held at 1:
  - LW: 5 cycles.
  - SW and RTYPE: 4 cycles.
  - BEQ and J: 3 cycles.
  - ADDI: 4 cycles.
- Each memory wait cycle adds one cycle.

Test Plan:
- Reset: hold i_rst=1 for 3 cycles with i_mem_ready=1 → all outputs 0. After release: o_state=0, o_ir_wr_en=1, o_pc_en=1, o_alu_src_b_sel=01.
- LW with i_mem_ready low for 2 cycles in FETCH and 2 cycles in MEMRD → state sequence 0,0,0,1,2,3,3,3,4,0. o_pc_en and o_ir_wr_en high only in the third FETCH cycle. o_reg_wr_en=1 with o_reg_wr_data_sel=1 in state 4.
- SW with ready delayed 1 cycle in MEMWR → o_mem_wr_en=1 for both MEMWR cycles with o_iord=1, then state 0.
- BEQ with i_zero=1, then repeated with i_zero=0 → in state 8, o_alu_cntrl=110 and o_pc_src_sel=01. o_pc_en=1 for i_zero=1 and 0 for i_zero=0.
- RTYPE with funct 101010 → o_alu_cntrl=111 in state 6, then o_reg_wr_en=1 with o_reg_wr_addr_sel=1 in state 7. RTYPE with funct 111111 → o_illegal=1 in state 6 and o_alu_cntrl=010.
- Opcode 111111 → o_illegal=1 in DECODE, next state 0, no write enable asserted. Separately, i_rst pulsed during MEMWR → o_mem_wr_en=0 in that cycle and state 0 next.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Instruction-register / datapath / memory bundle seen by the multicycle
// control unit. The master modport is the control unit itself; the slave
// modport is the datapath side that supplies decode fields and status.
interface multicycle_control_unit_if #(
  parameter int ALU_CNTRL_WIDTH_P = 3,
  parameter int FUNCT_WIDTH_P     = 6,
  parameter int OP_WIDTH_P        = 6,
  parameter int STATE_WIDTH_P     = 4
);
  logic [OP_WIDTH_P-1:0]        i_opcode;
  logic [FUNCT_WIDTH_P-1:0]     i_function;
  logic                         i_zero;
  logic                         i_mem_ready;
  logic                         o_iord;
  logic                         o_mem_wr_en;
  logic                         o_ir_wr_en;
  logic                         o_pc_en;
  logic [1:0]                   o_pc_src_sel;
  logic                         o_alu_src_a_sel;
  logic [1:0]                   o_alu_src_b_sel;
  logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl;
  logic                         o_reg_wr_addr_sel;
  logic                         o_reg_wr_data_sel;
  logic                         o_reg_wr_en;
  logic                         o_illegal;
  logic [STATE_WIDTH_P-1:0]     o_state;

  modport master (
    input  i_opcode, i_function, i_zero, i_mem_ready,
    output o_iord, o_mem_wr_en, o_ir_wr_en, o_pc_en, o_pc_src_sel,
           o_alu_src_a_sel, o_alu_src_b_sel, o_alu_cntrl,
           o_reg_wr_addr_sel, o_reg_wr_data_sel, o_reg_wr_en,
           o_illegal, o_state
  );

  modport slave (
    output i_opcode, i_function, i_zero, i_mem_ready,
    input  o_iord, o_mem_wr_en, o_ir_wr_en, o_pc_en, o_pc_src_sel,
           o_alu_src_a_sel, o_alu_src_b_sel, o_alu_cntrl,
           o_reg_wr_addr_sel, o_reg_wr_data_sel, o_reg_wr_en,
           o_illegal, o_state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath. Sequences each
// instruction through one shared memory and ALU, stalls on memory-ready,
// flags unsupported opcodes/functs and exposes the state for debug.
module multicycle_control_unit #(
  parameter int ALU_CNTRL_WIDTH_P = 3,
  parameter int FUNCT_WIDTH_P     = 6,
  parameter int OP_WIDTH_P        = 6,
  parameter int STATE_WIDTH_P     = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [STATE_WIDTH_P-1:0] {
    S_FETCH    = STATE_WIDTH_P'(0),
    S_DECODE   = STATE_WIDTH_P'(1),
    S_MEMADR   = STATE_WIDTH_P'(2),
    S_MEMRD    = STATE_WIDTH_P'(3),
    S_MEMWB    = STATE_WIDTH_P'(4),
    S_MEMWR    = STATE_WIDTH_P'(5),
    S_EXECUTE  = STATE_WIDTH_P'(6),
    S_ALUWB    = STATE_WIDTH_P'(7),
    S_BRANCH   = STATE_WIDTH_P'(8),
    S_ADDIEXEC = STATE_WIDTH_P'(9),
    S_ADDIWB   = STATE_WIDTH_P'(10),
    S_JUMP     = STATE_WIDTH_P'(11)
  } state_t;

  localparam logic [OP_WIDTH_P-1:0] OP_RTYPE = OP_WIDTH_P'(6'b000000);
  localparam logic [OP_WIDTH_P-1:0] OP_LW    = OP_WIDTH_P'(6'b100011);
  localparam logic [OP_WIDTH_P-1:0] OP_SW    = OP_WIDTH_P'(6'b101011);
  localparam logic [OP_WIDTH_P-1:0] OP_BEQ   = OP_WIDTH_P'(6'b000100);
  localparam logic [OP_WIDTH_P-1:0] OP_ADDI  = OP_WIDTH_P'(6'b001000);
  localparam logic [OP_WIDTH_P-1:0] OP_J     = OP_WIDTH_P'(6'b000010);

  localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_ADD = ALU_CNTRL_WIDTH_P'(3'b010);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_SUB = ALU_CNTRL_WIDTH_P'(3'b110);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_AND = ALU_CNTRL_WIDTH_P'(3'b000);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_OR  = ALU_CNTRL_WIDTH_P'(3'b001);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_SLT = ALU_CNTRL_WIDTH_P'(3'b111);

  // Unknown functs fall back to add so ALUWB still writes a defined result.
  function automatic logic [ALU_CNTRL_WIDTH_P:0] funct_decode(
    input logic [FUNCT_WIDTH_P-1:0] funct
  );
    case (funct)
      FUNCT_WIDTH_P'(6'b100000): funct_decode = {1'b0, ALU_ADD};
      FUNCT_WIDTH_P'(6'b100010): funct_decode = {1'b0, ALU_SUB};
      FUNCT_WIDTH_P'(6'b100100): funct_decode = {1'b0, ALU_AND};
      FUNCT_WIDTH_P'(6'b100101): funct_decode = {1'b0, ALU_OR};
      FUNCT_WIDTH_P'(6'b101010): funct_decode = {1'b0, ALU_SLT};
      default:                   funct_decode = {1'b1, ALU_ADD};
    endcase
  endfunction

  state_t r_state;
  state_t w_next_state;
  logic   w_pc_write;
  logic   w_branch;
  logic [ALU_CNTRL_WIDTH_P:0] w_funct_dec;

  assign w_funct_dec = funct_decode(bus.i_function);

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state selection.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = bus.i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.i_opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEXEC;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next_state = (bus.i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    w_next_state = bus.i_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    w_next_state = bus.i_mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  w_next_state = S_ALUWB;
      S_ADDIEXEC: w_next_state = S_ADDIWB;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Per-state datapath controls; reset overrides everything except o_state.
  always_comb begin
    bus.o_iord            = 1'b0;
    bus.o_mem_wr_en       = 1'b0;
    bus.o_ir_wr_en        = 1'b0;
    bus.o_pc_src_sel      = 2'b00;
    bus.o_alu_src_a_sel   = 1'b0;
    bus.o_alu_src_b_sel   = 2'b00;
    bus.o_alu_cntrl       = '0;
    bus.o_reg_wr_addr_sel = 1'b0;
    bus.o_reg_wr_data_sel = 1'b0;
    bus.o_reg_wr_en       = 1'b0;
    bus.o_illegal         = 1'b0;
    w_pc_write            = 1'b0;
    w_branch              = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.o_alu_src_b_sel = 2'b01;
        bus.o_alu_cntrl     = ALU_ADD;
        bus.o_ir_wr_en      = bus.i_mem_ready;
        w_pc_write          = bus.i_mem_ready;
      end
      S_DECODE: begin
        bus.o_alu_src_b_sel = 2'b11;
        bus.o_alu_cntrl     = ALU_ADD;
        bus.o_illegal       = !(bus.i_opcode inside {OP_RTYPE, OP_LW, OP_SW,
                                                     OP_BEQ, OP_ADDI, OP_J});
      end
      S_MEMADR, S_ADDIEXEC: begin
        bus.o_alu_src_a_sel = 1'b1;
        bus.o_alu_src_b_sel = 2'b10;
        bus.o_alu_cntrl     = ALU_ADD;
      end
      S_MEMRD: bus.o_iord = 1'b1;
      S_MEMWR: begin
        bus.o_iord      = 1'b1;
        bus.o_mem_wr_en = 1'b1;
      end
      S_MEMWB: begin
        bus.o_reg_wr_en       = 1'b1;
        bus.o_reg_wr_data_sel = 1'b1;
      end
      S_EXECUTE: begin
        bus.o_alu_src_a_sel = 1'b1;
        bus.o_alu_cntrl     = w_funct_dec[ALU_CNTRL_WIDTH_P-1:0];
        bus.o_illegal       = w_funct_dec[ALU_CNTRL_WIDTH_P];
      end
      S_ALUWB: begin
        bus.o_reg_wr_en       = 1'b1;
        bus.o_reg_wr_addr_sel = 1'b1;
      end
      S_ADDIWB: bus.o_reg_wr_en = 1'b1;
      S_BRANCH: begin
        bus.o_alu_src_a_sel = 1'b1;
        bus.o_alu_cntrl     = ALU_SUB;
        bus.o_pc_src_sel    = 2'b01;
        w_branch            = 1'b1;
      end
      S_JUMP: begin
        bus.o_pc_src_sel = 2'b10;
        w_pc_write       = 1'b1;
      end
      default: ;
    endcase
    bus.o_pc_en = w_pc_write | (w_branch & bus.i_zero);
    if (i_rst) begin
      bus.o_iord            = 1'b0;
      bus.o_mem_wr_en       = 1'b0;
      bus.o_ir_wr_en        = 1'b0;
      bus.o_pc_en           = 1'b0;
      bus.o_pc_src_sel      = 2'b00;
      bus.o_alu_src_a_sel   = 1'b0;
      bus.o_alu_src_b_sel   = 2'b00;
      bus.o_alu_cntrl       = '0;
      bus.o_reg_wr_addr_sel = 1'b0;
      bus.o_reg_wr_data_sel = 1'b0;
      bus.o_reg_wr_en       = 1'b0;
      bus.o_illegal         = 1'b0;
    end
  end

  assign bus.o_state = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios plus randomized
// instruction streams, each instruction expanded into its list of steps and
// every cycle's outputs compared with the step's expected controls.
module tb_multicycle_control_unit;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  multicycle_control_unit_if bus_if ();

  multicycle_control_unit dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus_if.master)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       iord, memwr, irwr, pcen;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic       wa, wd, rwe, ill;
  } exp_t;

  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected controls for a step, written straight from the output table.
  function automatic exp_t expect_out(input int st, input bit rdy, input bit z,
                                      input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    case (st)
      0: begin e.srcb = 2'b01; e.alu = 3'b010; e.irwr = rdy; e.pcen = rdy; end
      1: begin
        e.srcb = 2'b11; e.alu = 3'b010;
        e.ill = !(op == RTYPE || op == LW || op == SW || op == BEQ ||
                  op == ADDI || op == JMP);
      end
      2, 9: begin e.srca = 1; e.srcb = 2'b10; e.alu = 3'b010; end
      3: e.iord = 1;
      4: begin e.rwe = 1; e.wd = 1; end
      5: begin e.iord = 1; e.memwr = 1; end
      6: begin
        e.srca = 1;
        case (fn)
          6'b100000: e.alu = 3'b010;
          6'b100010: e.alu = 3'b110;
          6'b100100: e.alu = 3'b000;
          6'b100101: e.alu = 3'b001;
          6'b101010: e.alu = 3'b111;
          default: begin e.alu = 3'b010; e.ill = 1; end
        endcase
      end
      7: begin e.rwe = 1; e.wa = 1; end
      8: begin e.srca = 1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      10: e.rwe = 1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_outputs(input exp_t e, input bit chk_state, input string t);
    if (chk_state) check_val({t, ".state"}, 32'(bus_if.o_state), 32'(e.st));
    check_val({t, ".iord"},   32'(bus_if.o_iord),            32'(e.iord));
    check_val({t, ".memwr"},  32'(bus_if.o_mem_wr_en),       32'(e.memwr));
    check_val({t, ".irwr"},   32'(bus_if.o_ir_wr_en),        32'(e.irwr));
    check_val({t, ".pcen"},   32'(bus_if.o_pc_en),           32'(e.pcen));
    check_val({t, ".pcsrc"},  32'(bus_if.o_pc_src_sel),      32'(e.pcsrc));
    check_val({t, ".srca"},   32'(bus_if.o_alu_src_a_sel),   32'(e.srca));
    check_val({t, ".srcb"},   32'(bus_if.o_alu_src_b_sel),   32'(e.srcb));
    check_val({t, ".alu"},    32'(bus_if.o_alu_cntrl),       32'(e.alu));
    check_val({t, ".wa"},     32'(bus_if.o_reg_wr_addr_sel), 32'(e.wa));
    check_val({t, ".wd"},     32'(bus_if.o_reg_wr_data_sel), 32'(e.wd));
    check_val({t, ".rwe"},    32'(bus_if.o_reg_wr_en),       32'(e.rwe));
    check_val({t, ".ill"},    32'(bus_if.o_illegal),         32'(e.ill));
  endtask

  // Expand one instruction into its step list, drive it cycle by cycle and
  // check each cycle. rst_at >= 0 pulses reset at that step and abandons it.
  task automatic run_instr(input string tag, input logic [5:0] op,
                           input logic [5:0] fn, input bit z,
                           input int fw, input int mw, input int rst_at);
    int st_q[$];
    bit rdy_q[$];
    exp_t e;
    for (int k = 0; k < fw; k++) begin st_q.push_back(0); rdy_q.push_back(0); end
    st_q.push_back(0); rdy_q.push_back(1);
    st_q.push_back(1); rdy_q.push_back(1'($urandom));
    case (op)
      LW: begin
        st_q.push_back(2); rdy_q.push_back(1'($urandom));
        for (int k = 0; k < mw; k++) begin st_q.push_back(3); rdy_q.push_back(0); end
        st_q.push_back(3); rdy_q.push_back(1);
        st_q.push_back(4); rdy_q.push_back(1'($urandom));
      end
      SW: begin
        st_q.push_back(2); rdy_q.push_back(1'($urandom));
        for (int k = 0; k < mw; k++) begin st_q.push_back(5); rdy_q.push_back(0); end
        st_q.push_back(5); rdy_q.push_back(1);
      end
      RTYPE: begin
        st_q.push_back(6); rdy_q.push_back(1'($urandom));
        st_q.push_back(7); rdy_q.push_back(1'($urandom));
      end
      BEQ: begin st_q.push_back(8); rdy_q.push_back(1'($urandom)); end
      ADDI: begin
        st_q.push_back(9);  rdy_q.push_back(1'($urandom));
        st_q.push_back(10); rdy_q.push_back(1'($urandom));
      end
      JMP: begin st_q.push_back(11); rdy_q.push_back(1'($urandom)); end
      default: ;
    endcase
    for (int i = 0; i < st_q.size(); i++) begin
      @(negedge i_clk);
      bus_if.i_opcode    = op;
      bus_if.i_function  = fn;
      bus_if.i_zero      = z;
      bus_if.i_mem_ready = rdy_q[i];
      i_rst              = (i == rst_at);
      #1;
      if (i == rst_at) begin
        check_val({tag, ".rst_state"}, 32'(bus_if.o_state), 32'(st_q[i]));
        check_outputs('0, 1'b0, {tag, ".rst"});
        break;
      end
      e = expect_out(st_q[i], rdy_q[i], z, op, fn);
      check_outputs(e, 1'b1, tag);
    end
  endtask

  localparam logic [5:0] FUNCTS [6] = '{6'b100000, 6'b100010, 6'b100100,
                                        6'b100101, 6'b101010, 6'b111111};
  localparam logic [5:0] OPS [7] = '{RTYPE, LW, SW, BEQ, ADDI, JMP, 6'b111111};

  initial begin
    logic [5:0] op, fn;
    i_rst              = 1'b1;
    bus_if.i_opcode    = '0;
    bus_if.i_function  = '0;
    bus_if.i_zero      = 1'b0;
    bus_if.i_mem_ready = 1'b1;

    // Reset held three cycles: everything but the state reads zero.
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      #1;
      check_val("reset.state", 32'(bus_if.o_state), 32'd0);
      check_outputs('0, 1'b0, "reset");
    end

    run_instr("lw_stall",  LW,    6'b0,      1'b0, 2, 2, -1);
    run_instr("sw_wait",   SW,    6'b0,      1'b0, 0, 1, -1);
    run_instr("beq_z1",    BEQ,   6'b0,      1'b1, 0, 0, -1);
    run_instr("beq_z0",    BEQ,   6'b0,      1'b0, 0, 0, -1);
    run_instr("r_slt",     RTYPE, 6'b101010, 1'b0, 0, 0, -1);
    run_instr("r_bad",     RTYPE, 6'b111111, 1'b0, 0, 0, -1);
    run_instr("addi",      ADDI,  6'b0,      1'b0, 0, 0, -1);
    run_instr("jump",      JMP,   6'b0,      1'b0, 0, 0, -1);
    run_instr("bad_op",    6'b111111, 6'b0,  1'b0, 0, 0, -1);
    run_instr("sw_rst",    SW,    6'b0,      1'b0, 0, 2, 3);
    run_instr("after_rst", ADDI,  6'b0,      1'b0, 1, 0, -1);

    for (int n = 0; n < 200; n++) begin
      op = OPS[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : FUNCTS[$urandom_range(0, 5)];
      run_instr("rand", op, fn, 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 2),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    @(negedge i_clk);
    i_rst = 1'b0;
    bus_if.i_mem_ready = 1'b0;
    #1;
    check_val("final.state", 32'(bus_if.o_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
